pipeline_control_unit: RTL and testbench
========================================

// Module: pipeline_control_unit
// PURPOSE
//  Central stall/flush sequencer for the 5-stage core. Arbitrates between the hazard,
//  MDU, memory, branch and trap sources. Drives stall/flush of the IF/ID and ID/EX
//  registers, the PC source select and the busywait freeze, and keeps saturating
//  stall/flush performance counters.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles IF/ID/EX stay flushed after a trap/mret redirect (>=1)
//  CNT_W         32  width of performance counters
// PORTS
//  clk_i           in   1      clock, all state on rising edge
//  rst_ni          in   1      asynchronous active-low reset
//  load_stall_i    in   1      load-use hazard from ID hazard detection
//  mdu_start_i     in   1      multi-cycle MDU op entering EX this cycle
//  mdu_done_i      in   1      MDU result valid (1-cycle pulse)
//  mem_busy_i      in   1      data/instr memory busywait
//  branch_taken_i  in   1      branch/jump resolved taken in EX
//  exception_i     in   1      exception reaching commit
//  mret_i          in   1      mret reaching commit
//  stall_if_o      out  1      hold PC and IF/ID
//  stall_id_o      out  1      hold ID/EX inputs; to ID stall_id_i
//  busywait_o      out  1      global freeze of all pipeline registers
//  flush_id_o      out  1      IF/ID <= bubble; to ID branching_i
//  flush_ex_o      out  1      ID/EX <= bubble
//  pc_sel_o        out  2      00 seq, 01 branch target, 10 trap vector, 11 mepc
//  mdu_busy_o      out  1      FSM in MDU_WAIT
//  stall_cnt_o     out  CNT_W  cycles with stall_if_o|busywait_o, saturating
//  flush_cnt_o     out  CNT_W  redirect events (branch/trap/mret), saturating
// BEHAVIOUR
//  - Reset (rst_ni=0, async): state=RUN, flush counter 0, perf counters 0.
//    Outputs while in reset: flush_id_o=flush_ex_o=1, all others 0.
//  - FSM states: RUN, MDU_WAIT, MEM_WAIT, TRAP_FLUSH. Outputs are combinational from
//    state+inputs: zero-latency effect in the cycle the condition is seen.
//  - Priority per cycle: exception > mret > branch_taken > mem_busy > MDU > load_stall.
//  - RUN:
//    - exception_i: pc_sel=10, flush_id_o=flush_ex_o=1, -> TRAP_FLUSH, cnt=FLUSH_CYCLES-1.
//    - mret_i: same as exception but pc_sel=11.
//    - branch_taken_i: pc_sel=01, flush_id_o=flush_ex_o=1 for 1 cycle, stay in RUN.
//      Any coincident load_stall is ignored.
//    - mem_busy_i: busywait_o=1, -> MEM_WAIT.
//    - mdu_start_i: stall_if_o=stall_id_o=1, flush_ex_o=0, -> MDU_WAIT.
//      If mdu_done_i is high in the same cycle, stay in RUN with no stall.
//    - load_stall_i: stall_if_o=stall_id_o=1 for that cycle only (ID inserts the
//      bubble). No state change.
//  - MDU_WAIT: stall_if_o=stall_id_o=1 until mdu_done_i. On mdu_done_i, stalls drop in
//    that same cycle and the FSM goes -> RUN. Exception preempts: abandon, -> TRAP_FLUSH.
//    mem_busy in MDU_WAIT asserts busywait_o and keeps the state.
//  - MEM_WAIT: busywait_o=1 while mem_busy_i. Deassertion -> RUN in the same cycle, so
//    busywait_o follows mem_busy_i with zero latency. Exception/mret cannot arrive here:
//    commit is frozen.
//  - TRAP_FLUSH: flush_id_o=flush_ex_o=1, pc_sel=00. cnt decrements; at cnt==0 -> RUN.
//    With FLUSH_CYCLES=1 the state is skipped.
//    A new exception here restarts the count and re-drives pc_sel=10.
//    branch_taken_i, load_stall_i and mdu_start_i are ignored in this state.
//  - Counters: increment by 1 per qualifying cycle/event and hold at 2^CNT_W-1.
//    flush_cnt_o counts the initiating cycle only, not the extension cycles.
//  - Mid-operation async reset returns to RUN in the same edge-free instant. No partial
//    MDU state is retained.
// STRUCTURE
//  - pipeline_ctrl_pkg: state enum (2 bits), PC_SEL_SEQ/BR/TRAP/MEPC localparams.
//  - Sub-module sat_counter #(W): enable, async active-low reset, saturating. Used twice.
// TESTING
//  1. load_stall_i=1 for 1 cycle in RUN -> stall_if_o=stall_id_o=1 that cycle only,
//     flush 0, stall_cnt_o=1.
//  2. mdu_start_i, mdu_done_i 5 cycles later -> stall_if_o high exactly 5 cycles,
//     mdu_busy_o high 5 cycles, stall_cnt_o=5.
//  3. branch_taken_i && load_stall_i same cycle -> pc_sel_o=01, flush_id_o=1,
//     stall_if_o=0, flush_cnt_o=1.
//  4. exception_i during MDU_WAIT, FLUSH_CYCLES=2 -> pc_sel_o=10 one cycle,
//     flush_ex_o high 2 cycles, then RUN.
//  5. mem_busy_i 3 cycles then mret_i -> busywait_o 3 cycles, then pc_sel_o=11 and
//     2 flush cycles.
//  6. CNT_W=4, 20 stall cycles -> stall_cnt_o=15. rst_ni low mid MDU_WAIT -> outputs at
//     reset values immediately.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MDU_WAIT   = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_TRAP_FLUSH = 2'd3
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_TRAP = 2'b10;
  localparam logic [1:0] PC_SEL_MEPC = 2'b11;

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// Saturating event counter: counts enabled cycles, sticks at all-ones.
// Latency: count visible one cycle after the enabled cycle.
// Backpressure: none; the enable is sampled every cycle.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: increment only while enabled and not already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage core: arbitrates trap/mret/branch/mem/MDU/load-use.
// Latency: control outputs are combinational from state+inputs (zero-cycle effect).
// Backpressure: mem busywait freezes everything; MDU and load-use stall IF/ID only.
module pipeline_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_stall_i,
  input  logic             mdu_start_i,
  input  logic             mdu_done_i,
  input  logic             mem_busy_i,
  input  logic             branch_taken_i,
  input  logic             exception_i,
  input  logic             mret_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             busywait_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic [1:0]       pc_sel_o,
  output logic             mdu_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Holds the remaining extension cycles after the redirect cycle (max FLUSH_CYCLES-1).
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           stall, busy, flush_id, flush_ex;
  logic [1:0]     pc_sel;
  logic           run_rules, take_trap;

  // Next state and raw control outputs; traps are resolved last so they override.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    busy      = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    pc_sel    = PC_SEL_SEQ;
    run_rules = 1'b0;
    take_trap = 1'b0;

    unique case (state_q)
      ST_RUN: run_rules = 1'b1;
      ST_MEM_WAIT: begin
        // Leaving the freeze is handled like RUN so busywait tracks mem_busy exactly.
        if (mem_busy_i) begin
          busy = 1'b1;
        end else begin
          state_d   = ST_RUN;
          run_rules = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        if (exception_i || mret_i) begin
          take_trap = 1'b1;
        end else begin
          busy = mem_busy_i;
          if (mdu_done_i) begin
            state_d = ST_RUN;
          end else begin
            stall = 1'b1;
          end
        end
      end
      ST_TRAP_FLUSH: begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
        if (exception_i || mret_i) begin
          take_trap = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (run_rules) begin
      if (exception_i || mret_i) begin
        take_trap = 1'b1;
      end else if (branch_taken_i) begin
        pc_sel   = PC_SEL_BR;
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (mem_busy_i) begin
        busy    = 1'b1;
        state_d = ST_MEM_WAIT;
      end else if (mdu_start_i) begin
        // A single-cycle MDU result needs no wait at all.
        if (!mdu_done_i) begin
          stall   = 1'b1;
          state_d = ST_MDU_WAIT;
        end
      end else if (load_stall_i) begin
        stall = 1'b1;
      end
    end

    if (take_trap) begin
      pc_sel   = exception_i ? PC_SEL_TRAP : PC_SEL_MEPC;
      flush_id = 1'b1;
      flush_ex = 1'b1;
      stall    = 1'b0;
      busy     = 1'b0;
      cnt_d    = CW'(FLUSH_CYCLES - 1);
      state_d  = (FLUSH_CYCLES > 1) ? ST_TRAP_FLUSH : ST_RUN;
    end
  end

  // State and flush-extension counter; reset abandons any MDU wait.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While reset is held the pipeline is flushed and nothing else is asserted.
  assign stall_if_o = rst_ni & stall;
  assign stall_id_o = rst_ni & stall;
  assign busywait_o = rst_ni & busy;
  assign flush_id_o = ~rst_ni | flush_id;
  assign flush_ex_o = ~rst_ni | flush_ex;
  assign pc_sel_o   = rst_ni ? pc_sel : PC_SEL_SEQ;
  assign mdu_busy_o = rst_ni & (state_q == ST_MDU_WAIT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (stall_if_o | busywait_o),
    .cnt_o  (stall_cnt_o)
  );

  // Only the redirect cycle itself drives a non-sequential PC, so it marks one event.
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (pc_sel_o != PC_SEL_SEQ),
    .cnt_o  (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed scenarios plus random traffic vs a reference model.
// Latency: outputs sampled 1 time unit after the input-driving negedge.
// Backpressure: n/a.
module tb_pipeline_control_unit;

  localparam int FL  = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          load_stall_i, mdu_start_i, mdu_done_i, mem_busy_i;
  logic          branch_taken_i, exception_i, mret_i;
  logic          stall_if_o, stall_id_o, busywait_o, flush_id_o, flush_ex_o, mdu_busy_o;
  logic [1:0]    pc_sel_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending MDU op, memory freeze, remaining trap-flush cycles, counts.
  bit mdu_pend;
  bit frozen;
  int flush_left;
  int scnt, fcnt;

  pipeline_control_unit #(.FLUSH_CYCLES(FL), .CNT_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .load_stall_i   (load_stall_i),
    .mdu_start_i    (mdu_start_i),
    .mdu_done_i     (mdu_done_i),
    .mem_busy_i     (mem_busy_i),
    .branch_taken_i (branch_taken_i),
    .exception_i    (exception_i),
    .mret_i         (mret_i),
    .stall_if_o     (stall_if_o),
    .stall_id_o     (stall_id_o),
    .busywait_o     (busywait_o),
    .flush_id_o     (flush_id_o),
    .flush_ex_o     (flush_ex_o),
    .pc_sel_o       (pc_sel_o),
    .mdu_busy_o     (mdu_busy_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ctl_vec();
    return {stall_if_o, stall_id_o, busywait_o, flush_id_o, flush_ex_o, pc_sel_o, mdu_busy_o};
  endfunction

  task automatic zero_inputs();
    load_stall_i = 0; mdu_start_i = 0; mdu_done_i = 0; mem_busy_i = 0;
    branch_taken_i = 0; exception_i = 0; mret_i = 0;
  endtask

  // Async reset asserted mid-cycle; outputs must take reset values without a clock edge.
  task automatic reset_dut();
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    zero_inputs();
    #1;
    chk("rst_ctl", 32'(ctl_vec()), 32'b0001_1000);
    chk("rst_scnt", 32'(stall_cnt_o), 0);
    chk("rst_fcnt", 32'(flush_cnt_o), 0);
    mdu_pend = 0; frozen = 0; flush_left = 0; scnt = 0; fcnt = 0;
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit ls, input bit ms, input bit md, input bit mb,
                      input bit bt, input bit ex, input bit mr);
    bit       e_st, e_bw, e_fl, e_mb;
    bit       trap;
    bit [1:0] e_pc;
    @(negedge clk_i);
    load_stall_i = ls; mdu_start_i = ms; mdu_done_i = md; mem_busy_i = mb;
    branch_taken_i = bt; exception_i = ex; mret_i = mr;
    #1;
    e_st = 0; e_bw = 0; e_fl = 0; e_pc = 2'd0; e_mb = mdu_pend; trap = 0;
    if (flush_left > 0) begin
      e_fl = 1;
      if (ex || mr) trap = 1;
      else flush_left--;
    end else if (mdu_pend) begin
      if (ex || mr) trap = 1;
      else begin
        e_bw = mb;
        if (md) mdu_pend = 0;
        else e_st = 1;
      end
    end else if (frozen && mb) begin
      e_bw = 1;
    end else begin
      frozen = 0;
      if (ex || mr) trap = 1;
      else if (bt) begin e_pc = 2'd1; e_fl = 1; end
      else if (mb) begin e_bw = 1; frozen = 1; end
      else if (ms) begin
        if (!md) begin mdu_pend = 1; e_st = 1; end
      end
      else if (ls) e_st = 1;
    end
    if (trap) begin
      e_pc = ex ? 2'd2 : 2'd3;
      e_fl = 1;
      mdu_pend = 0;
      flush_left = FL - 1;
    end
    chk("ctl", 32'(ctl_vec()), 32'({e_st, e_st, e_bw, e_fl, e_fl, e_pc, e_mb}));
    chk("scnt", 32'(stall_cnt_o), 32'(scnt));
    chk("fcnt", 32'(flush_cnt_o), 32'(fcnt));
    if ((e_st || e_bw) && scnt < SAT) scnt++;
    if (e_pc != 2'd0 && fcnt < SAT) fcnt++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit ls, ms, md, mb, bt, ex, mr;
    rst_ni = 1'b0;
    zero_inputs();
    mdu_pend = 0; frozen = 0; flush_left = 0; scnt = 0; fcnt = 0;
    #1;
    chk("init_ctl", 32'(ctl_vec()), 32'b0001_1000);
    chk("init_scnt", 32'(stall_cnt_o), 0);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;

    // Load-use stall lasts exactly one cycle.
    idle();
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t1_stall", 32'(stall_if_o), 1);
    idle();
    chk("t1_stall_drop", 32'(stall_if_o), 0);
    chk("t1_scnt", 32'(stall_cnt_o), 1);

    // MDU op completing 5 cycles after start.
    reset_dut();
    step(0, 1, 0, 0, 0, 0, 0);
    repeat (4) idle();
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t2_done_stall", 32'(stall_if_o), 0);
    chk("t2_done_busy", 32'(mdu_busy_o), 1);
    idle();
    chk("t2_scnt", 32'(stall_cnt_o), 5);
    chk("t2_busy_drop", 32'(mdu_busy_o), 0);

    // Branch wins over a coincident load-use stall.
    reset_dut();
    step(1, 0, 0, 0, 1, 0, 0);
    chk("t3_pc", 32'(pc_sel_o), 1);
    chk("t3_stall", 32'(stall_if_o), 0);
    idle();
    chk("t3_fcnt", 32'(flush_cnt_o), 1);
    chk("t3_scnt", 32'(stall_cnt_o), 0);

    // Exception abandons an MDU wait.
    reset_dut();
    step(0, 1, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t4_pc", 32'(pc_sel_o), 2);
    idle();
    chk("t4_ext_flush", 32'(flush_ex_o), 1);
    chk("t4_ext_pc", 32'(pc_sel_o), 0);
    idle();
    chk("t4_run_flush", 32'(flush_ex_o), 0);
    chk("t4_fcnt", 32'(flush_cnt_o), 1);

    // Memory wait, then mret.
    reset_dut();
    repeat (3) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t5_pc", 32'(pc_sel_o), 3);
    chk("t5_bw", 32'(busywait_o), 0);
    idle();
    chk("t5_ext_flush", 32'(flush_id_o), 1);
    idle();
    chk("t5_run_flush", 32'(flush_id_o), 0);
    chk("t5_scnt", 32'(stall_cnt_o), 3);

    // Counter saturation, then reset in the middle of an MDU wait.
    reset_dut();
    repeat (20) step(1, 0, 0, 0, 0, 0, 0);
    idle();
    chk("t6_sat", 32'(stall_cnt_o), 15);
    step(0, 1, 0, 0, 0, 0, 0);
    idle();
    reset_dut();
    idle();

    // Random traffic; exceptions never arrive while memory is frozen,
    // and memory stays quiet during a trap flush.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) reset_dut();
      ls = ($urandom_range(0, 99) < 20);
      ms = ($urandom_range(0, 99) < 10);
      md = ($urandom_range(0, 99) < 25);
      mb = ($urandom_range(0, 99) < 15);
      bt = ($urandom_range(0, 99) < 10);
      ex = ($urandom_range(0, 99) < 4);
      mr = ($urandom_range(0, 99) < 3);
      if (frozen) begin ex = 0; mr = 0; end
      if (flush_left > 0) mb = 0;
      step(ls, ms, md, mb, bt, ex, mr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
